// File: rtl/multicycle_mem_responder_if.sv
// Request/response bundle between the control FSM (master) and the
// multicycle memory responder (slave).
interface multicycle_mem_responder_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] dout;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output addr, din, mem_read, mem_write,
    input  dout, ready, busy, err
  );

  modport slave (
    input  addr, din, mem_read, mem_write,
    output dout, ready, busy, err
  );
endinterface

// File: rtl/multicycle_mem_responder.sv
// Word-addressed memory that answers each read/write request after a fixed
// LATENCY with a one-cycle ready pulse, flagging malformed requests via err.
module multicycle_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int LATENCY         = 4
) (
  input logic                         clk,
  input logic                         reset,
  multicycle_mem_responder_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WORDS_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT                      state;
  logic [3:0]                 cnt;
  logic [ADDR_WORDS_LOG2-1:0] idxQ;
  logic [31:0]                dinQ;
  logic                       writeQ;
  logic                       reqErrQ;
  logic [31:0]                doutQ;
  logic                       readyQ;
  logic                       errQ;

  logic [31:0] mem [DEPTH];

  logic                       accept;
  logic                       enterResp;
  logic [ADDR_WORDS_LOG2-1:0] curIdx;
  logic [31:0]                curDin;
  logic                       curWrite;
  logic                       curErr;
  logic                       memWe;
  logic                       doutLoad;

  function automatic logic reqErrOf(input logic [31:0] a, input logic rd, input logic wr);
    return (rd && wr) || (a[1:0] != 2'b00) || ((a >> (ADDR_WORDS_LOG2 + 2)) != 32'd0);
  endfunction

  // With LATENCY=1 the commit edge is the sample edge, so the live request
  // is used in IDLE and the latched copy everywhere else.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    accept    = 1'b0;
    enterResp = 1'b0;
    curIdx    = idxQ;
    curDin    = dinQ;
    curWrite  = writeQ;
    curErr    = reqErrQ;
    if (state == IDLE) begin
      accept   = bus.mem_read || bus.mem_write;
      curIdx   = bus.addr[ADDR_WORDS_LOG2+1:2];
      curDin   = bus.din;
      curWrite = bus.mem_write;
      curErr   = reqErrOf(bus.addr, bus.mem_read, bus.mem_write);
    end
    if ((accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd0)))
      enterResp = 1'b1;
    memWe    = enterResp && curWrite && !curErr;
    doutLoad = enterResp && !curWrite && !curErr;
  end

  // NOTE: the array has no reset; its contents survive reset and an in-flight
  // write is dropped because reset forces state back to IDLE before commit.
  always_ff @(posedge clk) begin
    if (memWe) mem[curIdx] <= curDin;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idxQ    <= '0;
      dinQ    <= '0;
      writeQ  <= 1'b0;
      reqErrQ <= 1'b0;
      doutQ   <= '0;
      readyQ  <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      readyQ <= 1'b0;
      errQ   <= 1'b0;
      if (doutLoad) doutQ <= mem[curIdx];
      case (state)
        IDLE: begin
          if (accept) begin
            idxQ    <= curIdx;
            dinQ    <= curDin;
            writeQ  <= curWrite;
            reqErrQ <= curErr;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          // ready/err are registered off RESP, landing exactly LATENCY edges after the sample.
          readyQ <= 1'b1;
          errQ   <= reqErrQ;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout  = doutQ;
  assign bus.ready = readyQ;
  assign bus.err   = errQ;
  assign bus.busy  = (state != IDLE);

endmodule
